// File: rtl/bcd_div_arbiter_if.sv
// bcd_div_arbiter_if: requester, response and shared-divider signals of the BCD divide arbiter
interface bcd_div_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_dividend, req0_divisor;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_dividend, req1_divisor;
  logic        resp_valid, resp_id;
  logic [15:0] resp_quotient, resp_remainder;
  logic [1:0]  resp_err;
  logic        div_rst, div_start;
  logic [15:0] div_dividend, div_divisor;
  logic [15:0] div_quotient, div_remainder;
  logic        div_end;
  logic        busy;
  modport slave (
    input  req0_valid, req0_dividend, req0_divisor,
    input  req1_valid, req1_dividend, req1_divisor,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_quotient, resp_remainder, resp_err,
    output div_rst, div_start, div_dividend, div_divisor,
    input  div_quotient, div_remainder, div_end,
    output busy
  );
  modport master (
    output req0_valid, req0_dividend, req0_divisor,
    output req1_valid, req1_dividend, req1_divisor,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_quotient, resp_remainder, resp_err,
    input  div_rst, div_start, div_dividend, div_divisor,
    output div_quotient, div_remainder, div_end,
    input  busy
  );
endinterface

// File: rtl/bcd_div_arbiter.sv
// bcd_div_arbiter: round-robin sharing of one BCD divider between two requesters, with operand checks and timeout
module bcd_div_arbiter #(
  parameter int TIMEOUT = 50000
) (
  input logic clk,
  input logic rst,
  bcd_div_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, START, RUN, RESP} state_t;
  state_t state, state_n;
  logic        last_grant, cur_id;
  logic [15:0] cnt;
  logic        g0, g1, acc, tmo, zero, bad;
  logic [15:0] a_dvd, a_dvs;
  logic        rid;
  logic [15:0] rq, rr, dd, ds;
  logic [1:0]  rerr;

  function automatic logic bad_bcd(input logic [15:0] x);
    bad_bcd = 1'b0;
    for (int i = 0; i < 4; i++) bad_bcd = bad_bcd | (x[4*i +: 4] > 4'd9);
  endfunction

  assign g0    = bus.req0_valid & (~bus.req1_valid | last_grant);
  assign g1    = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  assign acc   = (state == IDLE) & (g0 | g1);
  assign a_dvd = g1 ? bus.req1_dividend : bus.req0_dividend;
  assign a_dvs = g1 ? bus.req1_divisor : bus.req0_divisor;
  assign zero  = a_dvs == 16'h0000;
  assign bad   = bad_bcd(a_dvd) | bad_bcd(a_dvs);
  // a completion arriving in the final RUN cycle beats the timeout
  assign tmo   = (state == RUN) & ~bus.div_end & (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (acc) state_n = (zero | bad) ? RESP : CLEAR;
      CLEAR:   state_n = START;
      START:   state_n = RUN;
      RUN:     if (bus.div_end | tmo) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cnt        <= '0;
      rid        <= 1'b0;
      rq         <= '0;
      rr         <= '0;
      rerr       <= 2'b00;
      dd         <= '0;
      ds         <= '0;
    end else begin
      if (acc) begin
        last_grant <= g1;
        cur_id     <= g1;
        if (zero | bad) begin
          rid  <= g1;
          rq   <= '0;
          rr   <= zero ? a_dvd : 16'h0000;
          rerr <= zero ? 2'b01 : 2'b10;
        end else begin
          dd <= a_dvd;
          ds <= a_dvs;
        end
      end
      if (state == START) cnt <= '0;
      else if (state == RUN) cnt <= cnt + 16'd1;
      if (state == RUN && bus.div_end) begin
        rid  <= cur_id;
        rq   <= bus.div_quotient;
        rr   <= bus.div_remainder;
        rerr <= 2'b00;
      end else if (tmo) begin
        rid  <= cur_id;
        rq   <= '0;
        rr   <= '0;
        rerr <= 2'b11;
      end
    end
  end

  assign bus.req0_ready     = (state == IDLE) & g0;
  assign bus.req1_ready     = (state == IDLE) & g1;
  assign bus.resp_valid     = state == RESP;
  assign bus.resp_id        = rid;
  assign bus.resp_quotient  = rq;
  assign bus.resp_remainder = rr;
  assign bus.resp_err       = rerr;
  // the divider's quotient register only clears on its reset, so reset it around every use
  assign bus.div_rst        = rst | (state == CLEAR) | tmo;
  assign bus.div_start      = state == START;
  assign bus.div_dividend   = dd;
  assign bus.div_divisor    = ds;
  assign bus.busy           = state != IDLE;
endmodule

// File: tb/tb_bcd_div_arbiter.sv
// tb_bcd_div_arbiter: directed checks of the BCD divide arbiter against a behavioural divider model
module tb_bcd_div_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;
  bcd_div_arbiter_if bus ();
  bcd_div_arbiter #(.TIMEOUT(20)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic        m_end = 1'b0, m_pend = 1'b0, hang = 1'b0, stray_end = 1'b0;
  logic [15:0] m_q = '0, m_r = '0;
  int          m_cnt = 0;
  int          n_start = 0, n_drst = 0;
  assign bus.div_end       = m_end | stray_end;
  assign bus.div_quotient  = m_q;
  assign bus.div_remainder = m_r;

  function automatic int b2i(input logic [15:0] x);
    return int'(x[15:12]) * 1000 + int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction
  function automatic logic [15:0] i2b(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  always @(posedge clk) begin
    m_end <= 1'b0;
    if (bus.div_rst) m_pend <= 1'b0;
    else if (bus.div_start) begin
      m_pend <= 1'b1;
      m_cnt  <= 3;
      m_q    <= (b2i(bus.div_divisor) == 0) ? 16'h0 : i2b(b2i(bus.div_dividend) / b2i(bus.div_divisor));
      m_r    <= (b2i(bus.div_divisor) == 0) ? 16'h0 : i2b(b2i(bus.div_dividend) % b2i(bus.div_divisor));
    end else if (m_pend && !hang) begin
      if (m_cnt == 0) begin
        m_end  <= 1'b1;
        m_pend <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (bus.div_start) n_start++;
    if (bus.div_rst && !rst) n_drst++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input string tag, output logic prev_end);
    int n;
    n = 0;
    prev_end = 1'b0;
    while (!bus.resp_valid && n < 100) begin
      prev_end = bus.div_end;
      tick();
      n++;
    end
    chk({tag, "_resp_seen"}, 32'(bus.resp_valid), 32'd1);
  endtask

  task automatic req(input bit id, input logic [15:0] dvd, input logic [15:0] dvs);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_dividend = dvd; bus.req1_divisor = dvs;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_dividend = dvd; bus.req0_divisor = dvs;
    end
    #1;
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    logic pe;
    int s0, r0, cnt_hi, rv_seen;
    logic [15:0] exp_q [3];
    logic        exp_id [3];
    bus.req0_valid = 1'b0; bus.req0_dividend = '0; bus.req0_divisor = '0;
    bus.req1_valid = 1'b0; bus.req1_dividend = '0; bus.req1_divisor = '0;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready0", 32'(bus.req0_ready), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_div_rst", 32'(bus.div_rst), 1);
    chk("rst_div_start", 32'(bus.div_start), 0);
    chk("rst_div_dividend", 32'(bus.div_dividend), 0);
    chk("rst_resp_err", 32'(bus.resp_err), 0);
    rst = 1'b0;
    tick();
    chk("idle_div_rst", 32'(bus.div_rst), 0);

    // normal divide
    req(0, 16'h1234, 16'h0012);
    chk("n_ready0", 32'(bus.req0_ready), 1);
    chk("n_ready1", 32'(bus.req1_ready), 0);
    tick();
    idle_reqs();
    chk("n_clear_div_rst", 32'(bus.div_rst), 1);
    chk("n_clear_start", 32'(bus.div_start), 0);
    chk("n_clear_ready0", 32'(bus.req0_ready), 0);
    chk("n_clear_busy", 32'(bus.busy), 1);
    chk("n_div_dividend", 32'(bus.div_dividend), 32'h1234);
    chk("n_div_divisor", 32'(bus.div_divisor), 32'h0012);
    tick();
    chk("n_start", 32'(bus.div_start), 1);
    chk("n_start_div_rst", 32'(bus.div_rst), 0);
    tick();
    wait_resp("n", pe);
    chk("n_latency", 32'(pe), 1);
    chk("n_id", 32'(bus.resp_id), 0);
    chk("n_q", 32'(bus.resp_quotient), 32'h0102);
    chk("n_r", 32'(bus.resp_remainder), 32'h0010);
    chk("n_err", 32'(bus.resp_err), 0);
    tick();
    chk("n_pulse", 32'(bus.resp_valid), 0);
    chk("n_hold_q", 32'(bus.resp_quotient), 32'h0102);
    chk("n_idle_busy", 32'(bus.busy), 0);

    // divide by zero
    s0 = n_start; r0 = n_drst;
    req(1, 16'h0500, 16'h0000);
    chk("z_ready1", 32'(bus.req1_ready), 1);
    tick();
    idle_reqs();
    chk("z_resp", 32'(bus.resp_valid), 1);
    chk("z_id", 32'(bus.resp_id), 1);
    chk("z_err", 32'(bus.resp_err), 32'b01);
    chk("z_q", 32'(bus.resp_quotient), 0);
    chk("z_r", 32'(bus.resp_remainder), 32'h0500);
    tick();
    chk("z_busy", 32'(bus.busy), 0);
    chk("z_no_start", 32'(n_start - s0), 0);
    chk("z_no_div_rst", 32'(n_drst - r0), 0);

    // invalid BCD
    req(0, 16'h12A4, 16'h0003);
    tick();
    idle_reqs();
    chk("b_resp", 32'(bus.resp_valid), 1);
    chk("b_id", 32'(bus.resp_id), 0);
    chk("b_err", 32'(bus.resp_err), 32'b10);
    chk("b_q", 32'(bus.resp_quotient), 0);
    chk("b_r", 32'(bus.resp_remainder), 0);
    chk("b_div_untouched", 32'(bus.div_dividend), 32'h1234);
    tick();

    // zero divisor outranks invalid BCD
    req(0, 16'h1A00, 16'h0000);
    tick();
    idle_reqs();
    chk("p_err", 32'(bus.resp_err), 32'b01);
    chk("p_r", 32'(bus.resp_remainder), 32'h1A00);
    tick();
    chk("p_no_start", 32'(n_start - s0), 0);

    // stray div_end while idle
    stray_end = 1'b1;
    tick();
    stray_end = 1'b0;
    chk("s_busy", 32'(bus.busy), 0);
    chk("s_resp", 32'(bus.resp_valid), 0);
    tick();
    chk("s_resp2", 32'(bus.resp_valid), 0);

    // round-robin from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_id = '{1'b0, 1'b1, 1'b0};
    exp_q  = '{16'h0010, 16'h0011, 16'h0010};
    req(0, 16'h0100, 16'h0010);
    req(1, 16'h0099, 16'h0009);
    chk("a_tie_ready0", 32'(bus.req0_ready), 1);
    chk("a_tie_ready1", 32'(bus.req1_ready), 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      wait_resp($sformatf("a%0d", i), pe);
      chk($sformatf("a%0d_id", i), 32'(bus.resp_id), 32'(exp_id[i]));
      chk($sformatf("a%0d_q", i), 32'(bus.resp_quotient), 32'(exp_q[i]));
      chk($sformatf("a%0d_r", i), 32'(bus.resp_remainder), 0);
    end
    idle_reqs();
    tick();

    // div_end coinciding with the timeout cycle
    hang = 1'b1;
    req(0, 16'h0999, 16'h0003);
    tick();
    idle_reqs();
    tick();
    cnt_hi = 0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (bus.div_rst || bus.resp_valid) cnt_hi++;
    end
    tick();
    stray_end = 1'b1;
    #1;
    chk("c_run_quiet", 32'(cnt_hi), 0);
    chk("c_no_tmo_rst", 32'(bus.div_rst), 0);
    tick();
    stray_end = 1'b0;
    chk("c_resp", 32'(bus.resp_valid), 1);
    chk("c_err", 32'(bus.resp_err), 0);
    chk("c_q", 32'(bus.resp_quotient), 32'h0333);
    tick();

    // timeout with a divider that never finishes
    r0 = n_drst;
    req(1, 16'h0999, 16'h0003);
    tick();
    idle_reqs();
    tick();
    cnt_hi = 0;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (bus.div_rst || bus.resp_valid) cnt_hi++;
    end
    chk("t_run_quiet", 32'(cnt_hi), 0);
    tick();
    chk("t_div_rst", 32'(bus.div_rst), 1);
    chk("t_resp_early", 32'(bus.resp_valid), 0);
    tick();
    chk("t_resp", 32'(bus.resp_valid), 1);
    chk("t_id", 32'(bus.resp_id), 1);
    chk("t_err", 32'(bus.resp_err), 32'b11);
    chk("t_q", 32'(bus.resp_quotient), 0);
    chk("t_r", 32'(bus.resp_remainder), 0);
    chk("t_div_rst_pulses", 32'(n_drst - r0), 2);
    tick();
    chk("t_busy", 32'(bus.busy), 0);
    hang = 1'b0;

    // reset during RUN
    req(0, 16'h0048, 16'h0004);
    tick();
    idle_reqs();
    tick(); tick(); tick();
    chk("r_in_run", 32'(bus.busy), 1);
    rst = 1'b1;
    rv_seen = 0;
    tick();
    chk("r_busy", 32'(bus.busy), 0);
    chk("r_resp_valid", 32'(bus.resp_valid), 0);
    chk("r_div_rst", 32'(bus.div_rst), 1);
    chk("r_resp_id", 32'(bus.resp_id), 0);
    chk("r_resp_err", 32'(bus.resp_err), 0);
    chk("r_div_dividend", 32'(bus.div_dividend), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.resp_valid) rv_seen++;
      if (i == 1) rst = 1'b0;
    end
    chk("r_no_resp", 32'(rv_seen), 0);
    req(0, 16'h0048, 16'h0004);
    tick();
    idle_reqs();
    wait_resp("r2", pe);
    chk("r2_id", 32'(bus.resp_id), 0);
    chk("r2_q", 32'(bus.resp_quotient), 32'h0012);
    chk("r2_r", 32'(bus.resp_remainder), 0);
    chk("r2_err", 32'(bus.resp_err), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_div_arbiter.md
BCD_DIV_ARBITER -- requirements
Module: bcd_div_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 50000, meaning: the maximum number of RUN cycles allowed before a division is aborted.
REQ-002 Clocking SHALL be one clock with a synchronous, active-high reset (clk, rst); all state updates on posedge clk.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req0_valid in 1, req0_ready out 1, req0_dividend in 16, req0_divisor in 16: requester 0, 4-digit BCD operands.
REQ-006 req1_valid in 1, req1_ready out 1, req1_dividend in 16, req1_divisor in 16: requester 1, same meaning.
REQ-007 resp_valid out 1 (one-cycle pulse), resp_id out 1 (requester served), resp_quotient out 16, resp_remainder out 16, resp_err out 2.
REQ-008 div_rst out 1, div_start out 1, div_dividend out 16, div_divisor out 16: drive the shared BCD divider.
REQ-009 div_quotient in 16, div_remainder in 16, div_end in 1: results and completion pulse from the shared divider.
REQ-010 busy out 1: high in every state except IDLE.

Function
REQ-011 FSM states SHALL be IDLE, CLEAR, START, RUN, RESP.
REQ-012 In IDLE, reqN_ready SHALL be high only for the granted requester; both ready outputs are low in all other states.
REQ-013 A request is accepted when reqN_valid and reqN_ready are high in the same cycle; the block captures operands and id in that cycle.
REQ-014 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not served last; if one is valid, grant it. The last_grant register resets to 1, so req0 wins the first tie.
REQ-015 On accept, if the divisor is 16'h0000, the FSM SHALL go to RESP with resp_err=01, quotient 16'h0000, remainder = dividend.
REQ-016 On accept, if any operand nibble > 9 (and the divisor is nonzero), the FSM SHALL go to RESP with resp_err=10, quotient 0, remainder 0.
REQ-017 Error checks SHALL have priority: zero divisor over invalid BCD. Neither error case asserts div_rst or div_start.
REQ-018 Otherwise the FSM SHALL go to CLEAR, pulse div_rst for one cycle, then go to START.
REQ-019 In START, the FSM SHALL pulse div_start for one cycle, then go to RUN. The div_rst pulse exists because the divider's quotient register clears only on its reset.
REQ-020 div_dividend and div_divisor SHALL hold the captured operands from CLEAR until the FSM leaves RUN, and stay stable otherwise.
REQ-021 In RUN, a 16-bit counter SHALL clear on entry and increment each cycle.
REQ-022 In RUN, when div_end=1, the block SHALL capture div_quotient and div_remainder, set resp_err=00, and go to RESP.
REQ-023 In RUN, when the counter reaches TIMEOUT-1 without div_end, the block SHALL go to RESP with resp_err=11, quotient 0, remainder 0, and pulse div_rst in that cycle.
REQ-024 If div_end and the timeout coincide, div_end SHALL win and the result is OK.
REQ-025 div_end outside RUN SHALL be ignored.
REQ-026 In RESP, resp_valid SHALL be high for exactly one cycle, then the FSM returns to IDLE. There is no response backpressure.
REQ-027 resp_id, resp_quotient, resp_remainder and resp_err SHALL hold their values until the next RESP.
REQ-028 Latency: error response 1 cycle after accept; normal response 1 cycle after div_end; div_start occurs 2 cycles after accept.
REQ-029 The block SHALL accept a new request no earlier than the IDLE cycle that follows RESP.

Reset
REQ-030 When rst=1, the following SHALL reset: state=IDLE, last_grant=1, counter=0, resp_valid=0, resp_id=0, resp_quotient=0, resp_remainder=0, resp_err=00, div_start=0, div_rst=1, div_dividend=0, div_divisor=0, both ready outputs=0, busy=0.
REQ-031 Reset mid-operation SHALL abandon the current request with no response; div_rst is high during rst, so the divider is cleared too.

Verification
REQ-032 Bench scenario, normal divide: req0 accepts 16'h1234 / 16'h0012 -> div_rst then div_start pulse; resp_valid with id 0, quotient 16'h0102, remainder 16'h0010, err 00.
REQ-033 Bench scenario, divide by zero: req1 accepts 16'h0500 / 16'h0000 -> resp_valid 1 cycle later, err 01, quotient 0, remainder 16'h0500; div_start never asserted.
REQ-034 Bench scenario, invalid BCD: req0 accepts 16'h12A4 / 16'h0003 -> err 10 one cycle after accept; divider untouched.
REQ-035 Bench scenario, arbitration: both requesters valid continuously after reset (0x0100/0x0010 and 0x0099/0x0009) -> grants alternate 0,1,0; results 0010 r0000 and 0011 r0000.
REQ-036 Bench scenario, timeout: TIMEOUT=20 with a divider model that never pulses div_end -> err 11 in the 20th RUN cycle, with div_rst pulsed and busy low after RESP.
REQ-037 Bench scenario, reset mid-RUN: rst asserted -> no resp_valid, all outputs at reset values; the next request completes correctly.
